// File: rtl/udp_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one UDP TX byte stream between two sources.
// Optional mid-packet stall timeout with forced flush is enabled by defining UDP_ARB_TIMEOUT_EN.
module udp_tx_arbiter #(
  parameter logic [15:0] C_TIMEOUT  = 16'd1024,
  parameter logic        C_S0_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        s0_valid,
  input  logic [7:0]  s0_data,
  input  logic [15:0] s0_length,
  input  logic        s0_last,
  input  logic        s0_reset,
  output logic        s0_ready,
  input  logic        s1_valid,
  input  logic [7:0]  s1_data,
  input  logic [15:0] s1_length,
  input  logic        s1_last,
  input  logic        s1_reset,
  output logic        s1_ready,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic        tx_last,
  output logic [15:0] tx_length,
  output logic        tx_reset,
  output logic        err_len,
  output logic [7:0]  debug
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT0  = 2'd1,
    GNT1  = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        prio_s1_q, prio_s1_d;
  logic [15:0] len_q, len_d;
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;

  logic        gnt0, gnt1;
  logic        sel_valid, sel_last, beat;
  logic        pick_s1;
  logic [15:0] cnt_inc;
  logic        drop_rst;

`ifdef UDP_ARB_TIMEOUT_EN
  logic [15:0] idle_q, idle_d;
`else
  logic        unused_timeout;
  assign unused_timeout = ^C_TIMEOUT;
`endif

  assign gnt0      = (state_q == GNT0);
  assign gnt1      = (state_q == GNT1);
  assign sel_valid = (gnt0 && s0_valid) || (gnt1 && s1_valid);
  assign sel_last  = gnt1 ? s1_last : s0_last;
  assign beat      = sel_valid && tx_ready;
  // The pointer only matters on a tie; a lone requester always wins.
  assign pick_s1   = s1_valid && (!s0_valid || prio_s1_q);
  assign cnt_inc   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

  always_comb begin
    state_d   = state_q;
    prio_s1_d = prio_s1_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
`ifdef UDP_ARB_TIMEOUT_EN
    idle_d    = idle_q;
`endif
    case (state_q)
      IDLE: begin
        if (enable && (s0_valid || s1_valid)) begin
          state_d = pick_s1 ? GNT1 : GNT0;
          len_d   = pick_s1 ? s1_length : s0_length;
          cnt_d   = 16'd0;
`ifdef UDP_ARB_TIMEOUT_EN
          idle_d  = 16'd0;
`endif
        end
      end
      GNT0, GNT1: begin
        if (beat) begin
          cnt_d = cnt_inc;
          if (sel_last) begin
            if (cnt_inc != len_q) err_d = 1'b1;
            state_d   = IDLE;
            prio_s1_d = gnt0;
          end
        end
`ifdef UDP_ARB_TIMEOUT_EN
        if (sel_valid) begin
          idle_d = 16'd0;
        end else if (idle_q == C_TIMEOUT - 16'd1) begin
          state_d   = FLUSH;
          prio_s1_d = gnt0;
          idle_d    = 16'd0;
        end else begin
          idle_d = idle_q + 16'd1;
        end
`endif
      end
      default: begin
        state_d = IDLE;
        err_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      prio_s1_q <= ~C_S0_FIRST;
      len_q     <= 16'd0;
      cnt_q     <= 16'd0;
      err_q     <= 1'b0;
`ifdef UDP_ARB_TIMEOUT_EN
      idle_q    <= 16'd0;
`endif
    end else begin
      state_q   <= state_d;
      prio_s1_q <= prio_s1_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
`ifdef UDP_ARB_TIMEOUT_EN
      idle_q    <= idle_d;
`endif
    end
  end

  // Outputs are forced to their reset values while rst is held.
  always_comb begin
    s0_ready  = 1'b0;
    s1_ready  = 1'b0;
    tx_data   = 8'h00;
    tx_valid  = 1'b0;
    tx_last   = 1'b0;
    tx_length = 16'd0;
    tx_reset  = 1'b0;
    drop_rst  = 1'b0;
    err_len   = 1'b0;
    debug     = 8'h00;
    if (!rst) begin
      tx_length = len_q;
      err_len   = err_q;
      case (state_q)
        IDLE: begin
          tx_reset = s0_reset || s1_reset;
        end
        GNT0: begin
          s0_ready = tx_ready;
          tx_data  = s0_data;
          tx_valid = s0_valid;
          tx_last  = s0_last;
          tx_reset = s0_reset;
          drop_rst = s1_reset;
        end
        GNT1: begin
          s1_ready = tx_ready;
          tx_data  = s1_data;
          tx_valid = s1_valid;
          tx_last  = s1_last;
          tx_reset = s1_reset;
          drop_rst = s0_reset;
        end
        default: begin
          tx_reset = 1'b1;
          drop_rst = s0_reset || s1_reset;
        end
      endcase
      debug = {gnt1, gnt0, state_q, drop_rst, err_q, tx_last, tx_valid};
    end
  end

endmodule
